instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: turns decoded operation requests into 32-bit
// instruction words and writes them sequentially into an instruction memory.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; clr resets pointer/count
// S_WRITE | write strobe high, word/address held until imem_ack
// S_FULL  | last address written; requests ignored until clr

module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              clr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              full,
    output logic [ADDR_W:0]   wr_count
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    localparam logic [5:0] OPC_ADD  = 6'b100010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_SUBI = 6'b111000;
    localparam logic [5:0] OPC_LW   = 6'b000011;
    localparam logic [5:0] OPC_SW   = 6'b001011;
    localparam logic [5:0] OPC_BEQ  = 6'b110100;
    localparam logic [5:0] OPC_BNE  = 6'b110101;
    localparam logic [5:0] OPC_JUMP = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]     r_wr_count;
    logic [ADDR_W:0]     w_wr_count_nxt;
    logic                r_imem_we;
    logic                w_imem_we_nxt;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [ADDR_W-1:0]   w_imem_addr_nxt;
    logic [31:0]         r_imem_wdata;
    logic [31:0]         w_imem_wdata_nxt;
    logic                r_full;
    logic                w_full_nxt;
    logic [31:0]         w_enc_word;
    logic [15:0]         w_br_off;

    // Branch offset is relative to the word after the one being written;
    // the 16-bit subtraction wraps silently.
    assign w_br_off = in_imm[15:0] - (16'(r_wr_ptr) + 16'd1);

    // Combinational encoding of the incoming request.
    always_comb begin
        w_enc_word = 32'd0;
        case (in_op)
            3'd0: w_enc_word = {OPC_ADD,  in_rs, in_rt, in_rd, 11'd0};
            3'd1: w_enc_word = {OPC_ADDI, in_rs, in_rt, in_imm[15:0]};
            3'd2: w_enc_word = {OPC_SUBI, in_rs, in_rt, in_imm[15:0]};
            3'd3: w_enc_word = {OPC_LW,   in_rs, in_rt, in_imm[15:0]};
            3'd4: w_enc_word = {OPC_SW,   in_rs, in_rt, in_imm[15:0]};
            3'd5: w_enc_word = {OPC_BEQ,  in_rs, in_rt, w_br_off};
            3'd6: w_enc_word = {OPC_BNE,  in_rs, in_rt, w_br_off};
            default: w_enc_word = {OPC_JUMP, in_imm};
        endcase
    end

    // Next-state and next-output decode; every output besides in_ready is
    // computed here and registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_wr_count_nxt   = r_wr_count;
        w_imem_we_nxt    = r_imem_we;
        w_imem_addr_nxt  = r_imem_addr;
        w_imem_wdata_nxt = r_imem_wdata;
        w_full_nxt       = r_full;
        case (r_state)
            S_IDLE: begin
                w_imem_we_nxt = 1'b0;
                w_full_nxt    = 1'b0;
                if (clr) begin
                    w_wr_ptr_nxt   = '0;
                    w_wr_count_nxt = '0;
                end else if (in_valid) begin
                    w_imem_wdata_nxt = w_enc_word;
                    w_imem_addr_nxt  = r_wr_ptr;
                    w_imem_we_nxt    = 1'b1;
                    w_state_nxt      = S_WRITE;
                end
            end
            S_WRITE: begin
                // clr is deliberately not looked at: the pending write completes.
                if (imem_ack) begin
                    w_wr_count_nxt = r_wr_count + CNT_ONE;
                    w_imem_we_nxt  = 1'b0;
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_full_nxt  = 1'b1;
                        w_state_nxt = S_FULL;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            S_FULL: begin
                w_imem_we_nxt = 1'b0;
                w_full_nxt    = 1'b1;
                if (clr) begin
                    w_wr_ptr_nxt   = '0;
                    w_wr_count_nxt = '0;
                    w_full_nxt     = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_imem_we_nxt = 1'b0;
                w_full_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_wr_count   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_full       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_wr_count   <= w_wr_count_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_wdata <= w_imem_wdata_nxt;
            r_full       <= w_full_nxt;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign full       = r_full;
    assign wr_count   = r_wr_count;

endmodule
